axi_lite_mem_responder: RTL and testbench



---
 rtl/axi_lite_mem_pkg.sv | 15 +
 rtl/axi_lite_mem_responder_resp_fifo.sv | 53 +++++
 rtl/axi_lite_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_axi_lite_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_mem_pkg.sv
// Shared response codes and read-return entry type for the AXI-Lite memory responder.
package axi_lite_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Sized for the widest supported bus; narrower instances use the low bits.
  localparam int unsigned MAX_DATA_WIDTH = 64;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
  } r_entry_t;

endpackage

// File: rtl/axi_lite_mem_responder_resp_fifo.sv
// Small synchronous FIFO holding queued R or B responses; head is visible combinationally.
module resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [1:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  T                mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full_o     = (count == (PW+1)'(DEPTH));
  assign empty_o    = (count == '0);
  assign count_o    = count;
  assign pop_data_o = mem[rd_ptr];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI-Lite slave memory model: fixed-latency in-order reads, held AW/W write commit,
// SLVERR for out-of-range addresses, and a direct preload port.
module axi_lite_mem_responder
  import axi_lite_mem_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH   = 32,
  parameter int unsigned             DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned             DEPTH_WORDS  = 1024,
  parameter int unsigned             READ_LATENCY = 2,
  parameter int unsigned             OUTSTANDING  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [DATA_WIDTH-1:0]          r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  input  logic                           init_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr_i,
  input  logic [DATA_WIDTH-1:0]          init_wdata_i,
  output logic [31:0]                    rd_count_o,
  output logic [31:0]                    wr_count_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;
  localparam int unsigned PIPE  = READ_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[OFF_W +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // ---------------- read path ----------------
  logic             ar_hs;
  r_entry_t         ar_entry;
  r_entry_t         r_push_entry;
  logic             r_push;
  r_entry_t         r_head;
  logic             r_full;
  logic             r_empty;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      pipe_cnt;

  assign ar_hs = ar_valid_i && ar_ready_o;

  // Memory is read in the handshake cycle, so same-cycle writes/preloads land after the sample.
  always_comb begin
    ar_entry      = '0;
    ar_entry.resp = RESP_SLVERR;
    if (in_range(ar_addr_i)) begin
      ar_entry.data[DATA_WIDTH-1:0] = mem[word_idx(ar_addr_i)];
      ar_entry.resp                 = RESP_OKAY;
    end
  end

  generate
    if (PIPE == 0) begin : g_direct
      assign r_push       = ar_hs;
      assign r_push_entry = ar_entry;
      assign pipe_cnt     = '0;
    end else begin : g_pipe
      logic [PIPE-1:0] vld;
      r_entry_t        ent [PIPE];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld <= '0;
        end else begin
          vld[0] <= ar_hs;
          for (int unsigned i = 1; i < PIPE; i++) vld[i] <= vld[i-1];
        end
      end

      always_ff @(posedge clk_i) begin
        ent[0] <= ar_entry;
        for (int unsigned i = 1; i < PIPE; i++) ent[i] <= ent[i-1];
      end

      always_comb begin
        pipe_cnt = '0;
        for (int unsigned i = 0; i < PIPE; i++) pipe_cnt = pipe_cnt + 32'(vld[i]);
      end

      assign r_push       = vld[PIPE-1];
      assign r_push_entry = ent[PIPE-1];
    end
  endgenerate

  resp_fifo #(
    .DEPTH (OUTSTANDING),
    .T     (r_entry_t)
  ) u_r_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (r_push),
    .push_data_i (r_push_entry),
    .pop_i       (r_valid_o && r_ready_i),
    .pop_data_o  (r_head),
    .full_o      (r_full),
    .empty_o     (r_empty),
    .count_o     (r_count)
  );

  assign ar_ready_o = !rst_i && !r_full && ((pipe_cnt + 32'(r_count)) < 32'(OUTSTANDING));
  assign r_valid_o  = !r_empty;
  assign r_data_o   = r_valid_o ? r_head.data[DATA_WIDTH-1:0] : '0;
  assign r_resp_o   = r_valid_o ? r_head.resp : '0;

  // ---------------- write path ----------------
  logic                    aw_held;
  logic                    w_held;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [BYTES-1:0]        w_strb_q;
  logic                    aw_ok;
  logic                    commit;
  logic [1:0]              b_head;
  logic                    b_full;
  logic                    b_empty;

  assign aw_ready_o = !rst_i && !aw_held;
  assign w_ready_o  = !rst_i && !w_held;
  assign aw_ok      = in_range(aw_addr_q);
  assign commit     = !rst_i && aw_held && w_held && !b_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_valid_i && aw_ready_o) begin
        aw_held   <= 1'b1;
        aw_addr_q <= aw_addr_i;
      end else if (commit) begin
        aw_held <= 1'b0;
      end
      if (w_valid_i && w_ready_o) begin
        w_held   <= 1'b1;
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
      end else if (commit) begin
        w_held <= 1'b0;
      end
    end
  end

  // Preload is applied last so it overrides a same-cycle AXI commit to the same word.
  always_ff @(posedge clk_i) begin
    if (commit && aw_ok) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (w_strb_q[b]) mem[word_idx(aw_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
    if (init_we_i) mem[init_addr_i] <= init_wdata_i;
  end

  resp_fifo #(
    .DEPTH (OUTSTANDING),
    .T     (logic [1:0])
  ) u_b_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (commit),
    .push_data_i (aw_ok ? RESP_OKAY : RESP_SLVERR),
    .pop_i       (b_valid_o && b_ready_i),
    .pop_data_o  (b_head),
    .full_o      (b_full),
    .empty_o     (b_empty),
    .count_o     ()
  );

  assign b_valid_o = !b_empty;
  assign b_resp_o  = b_valid_o ? b_head : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      if (r_valid_o && r_ready_i) rd_count_o <= rd_count_o + 32'd1;
      if (b_valid_o && b_ready_i) wr_count_o <= wr_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder: vector table of single transactions plus timing sequences.
module tb_axi_lite_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] aw_addr_i;
  logic        aw_valid_i;
  logic        aw_ready_o;
  logic [31:0] w_data_i;
  logic [3:0]  w_strb_i;
  logic        w_valid_i;
  logic        w_ready_o;
  logic [1:0]  b_resp_o;
  logic        b_valid_o;
  logic        b_ready_i;
  logic [31:0] ar_addr_i;
  logic        ar_valid_i;
  logic        ar_ready_o;
  logic [31:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_valid_o;
  logic        r_ready_i;
  logic        init_we_i;
  logic [9:0]  init_addr_i;
  logic [31:0] init_wdata_i;
  logic [31:0] rd_count_o;
  logic [31:0] wr_count_o;

  always #5 clk_i = ~clk_i;

  axi_lite_mem_responder #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .BASE_ADDR    (32'h8000_0000),
    .DEPTH_WORDS  (1024),
    .READ_LATENCY (2),
    .OUTSTANDING  (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .aw_addr_i    (aw_addr_i),
    .aw_valid_i   (aw_valid_i),
    .aw_ready_o   (aw_ready_o),
    .w_data_i     (w_data_i),
    .w_strb_i     (w_strb_i),
    .w_valid_i    (w_valid_i),
    .w_ready_o    (w_ready_o),
    .b_resp_o     (b_resp_o),
    .b_valid_o    (b_valid_o),
    .b_ready_i    (b_ready_i),
    .ar_addr_i    (ar_addr_i),
    .ar_valid_i   (ar_valid_i),
    .ar_ready_o   (ar_ready_o),
    .r_data_o     (r_data_o),
    .r_resp_o     (r_resp_o),
    .r_valid_o    (r_valid_o),
    .r_ready_i    (r_ready_i),
    .init_we_i    (init_we_i),
    .init_addr_i  (init_addr_i),
    .init_wdata_i (init_wdata_i),
    .rd_count_o   (rd_count_o),
    .wr_count_o   (wr_count_o)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t        vecs [12];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_rd = 0;
  int unsigned exp_wr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(posedge clk_i); #1;
    init_we_i = 1'b1; init_addr_i = idx; init_wdata_i = data;
    @(posedge clk_i); #1;
    init_we_i = 1'b0;
  endtask

  // Returns at the negedge where the R beat is visible; it is taken on the next posedge.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int unsigned n;
    @(posedge clk_i); #1;
    ar_addr_i = addr; ar_valid_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!ar_ready_o && n < 20) begin @(negedge clk_i); n++; end
    if (!ar_ready_o) chk("ar_ready_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    n = 0;
    @(negedge clk_i);
    while (!r_valid_o && n < 20) begin @(negedge clk_i); n++; end
    if (!r_valid_o) chk("r_valid_timeout", 64'd0, 64'd1);
    data = r_data_o; resp = r_resp_o;
    if (r_valid_o && r_ready_i) exp_rd++;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    int unsigned n;
    @(posedge clk_i); #1;
    aw_addr_i = addr; aw_valid_i = 1'b1;
    w_data_i = data; w_strb_i = strb; w_valid_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!(aw_ready_o && w_ready_o) && n < 20) begin @(negedge clk_i); n++; end
    if (!(aw_ready_o && w_ready_o)) chk("aw_w_ready_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    n = 0;
    @(negedge clk_i);
    while (!b_valid_o && n < 20) begin @(negedge clk_i); n++; end
    if (!b_valid_o) chk("b_valid_timeout", 64'd0, 64'd1);
    resp = b_resp_o;
    if (b_valid_o && b_ready_i) exp_wr++;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  rs;
    logic [31:0] got [4];
    int unsigned k;
    int unsigned seen;

    rst_i = 1'b1;
    aw_addr_i = '0; aw_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_valid_i = 1'b0;
    b_ready_i = 1'b1; ar_addr_i = '0; ar_valid_i = 1'b0; r_ready_i = 1'b1;
    init_we_i = 1'b0; init_addr_i = '0; init_wdata_i = '0;

    vecs[0]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0006, 32'h0, 4'h0, 32'hAABB_CCDD, 2'b00};
    vecs[2]  = '{1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0000_0000, 2'b10};
    vecs[3]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0000_0000, 2'b10};
    vecs[4]  = '{1'b1, 32'h8000_0FFC, 32'h1234_5678, 4'hF, 32'h0, 2'b00};
    vecs[5]  = '{1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'h1234_5678, 2'b00};
    vecs[6]  = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[8]  = '{1'b1, 32'h8000_0008, 32'h0000_00FF, 4'b0001, 32'h0, 2'b00};
    vecs[9]  = '{1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h5555_55FF, 2'b00};
    vecs[10] = '{1'b1, 32'h8000_0009, 32'hAB00_0000, 4'b1000, 32'h0, 2'b00};
    vecs[11] = '{1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'hAB55_55FF, 2'b00};

    // Reset values.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ar_ready", 64'(ar_ready_o), 64'd0);
    chk("rst_aw_w_ready", 64'({aw_ready_o, w_ready_o}), 64'd0);
    chk("rst_valids", 64'({r_valid_o, b_valid_o}), 64'd0);
    chk("rst_counts", {rd_count_o, wr_count_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_readies", 64'({ar_ready_o, aw_ready_o, w_ready_o}), 64'b111);

    preload(10'd0, 32'hDEAD_BEEF);
    preload(10'd1, 32'hAABB_CCDD);
    preload(10'd2, 32'h5555_5555);
    preload(10'd3, 32'h0000_0001);
    for (int i = 4; i < 8; i++) preload(10'(i), 32'hA5A5_0000 | 32'(i));

    // First-read latency: handshake at t, r_valid at t+2.
    @(posedge clk_i); #1;
    ar_addr_i = 32'h8000_0000; ar_valid_i = 1'b1;
    @(negedge clk_i);
    chk("lat_ar_ready", 64'(ar_ready_o), 64'd1);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    @(negedge clk_i);
    chk("lat_rvalid_t1", 64'(r_valid_o), 64'd0);
    @(negedge clk_i);
    chk("lat_rvalid_t2", 64'(r_valid_o), 64'd1);
    chk("lat_rdata", 64'(r_data_o), 64'hDEAD_BEEF);
    chk("lat_rresp", 64'(r_resp_o), 64'd0);
    exp_rd++;
    @(negedge clk_i);
    chk("lat_rd_count", 64'(rd_count_o), 64'd1);

    // Table-driven single transactions.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
        chk($sformatf("vec%0d_bresp", i), 64'(rs), 64'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, d, rs);
        chk($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].exp_data));
        chk($sformatf("vec%0d_rresp", i), 64'(rs), 64'(vecs[i].exp_resp));
      end
    end
    @(negedge clk_i);
    chk("tbl_rd_count", 64'(rd_count_o), 64'(exp_rd));
    chk("tbl_wr_count", 64'(wr_count_o), 64'(exp_wr));

    // Outstanding limit: four reads with R stalled, then drain in order.
    r_ready_i = 1'b0;
    @(posedge clk_i); #1;
    ar_valid_i = 1'b1; ar_addr_i = 32'h8000_0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk($sformatf("fill_ar_ready%0d", i), 64'(ar_ready_o), 64'd1);
      @(posedge clk_i); #1;
      ar_addr_i = 32'h8000_0014 + 32'(4 * i);
    end
    @(negedge clk_i);
    chk("full_ar_ready", 64'(ar_ready_o), 64'd0);
    chk("stall_rdata", 64'(r_data_o), 64'hA5A5_0004);
    ar_valid_i = 1'b0;
    r_ready_i  = 1'b1;
    k = 0;
    for (int n = 0; n < 20 && k < 4; n++) begin
      if (r_valid_o) begin got[k] = r_data_o; k++; end
      @(negedge clk_i);
    end
    chk("drain_beats", 64'(k), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain_data%0d", i), 64'(got[i]), 64'hA5A5_0004 + 64'(i));
    exp_rd += k;
    chk("drain_ar_ready", 64'(ar_ready_o), 64'd1);

    // W two cycles ahead of AW; partial strobe merge.
    @(posedge clk_i); #1;
    w_data_i = 32'h1122_3344; w_strb_i = 4'b0101; w_valid_i = 1'b1;
    @(negedge clk_i);
    chk("early_w_ready", 64'(w_ready_o), 64'd1);
    @(posedge clk_i); #1;
    w_valid_i = 1'b0;
    @(negedge clk_i);
    chk("w_held_ready", 64'({w_ready_o, aw_ready_o}), 64'b01);
    @(posedge clk_i); #1;
    aw_addr_i = 32'h8000_0004; aw_valid_i = 1'b1;
    @(negedge clk_i);
    chk("late_aw_ready", 64'(aw_ready_o), 64'd1);
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    @(negedge clk_i);
    chk("bvalid_t1", 64'(b_valid_o), 64'd0);
    @(negedge clk_i);
    chk("bvalid_t2", 64'(b_valid_o), 64'd1);
    chk("bresp_t2", 64'(b_resp_o), 64'd0);
    exp_wr++;
    do_read(32'h8000_0004, d, rs);
    chk("merge_rdata", 64'(d), 64'hAA22_CC44);

    // AR and commit to word 3 in the same cycle: read sees old value.
    @(posedge clk_i); #1;
    aw_addr_i = 32'h8000_000C; aw_valid_i = 1'b1;
    w_data_i = 32'h0000_0002; w_strb_i = 4'hF; w_valid_i = 1'b1;
    @(negedge clk_i);
    chk("coll_aw_w_ready", 64'({aw_ready_o, w_ready_o}), 64'b11);
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0; w_valid_i = 1'b0;
    ar_addr_i = 32'h8000_000C; ar_valid_i = 1'b1;
    @(negedge clk_i);
    chk("coll_ar_ready", 64'(ar_ready_o), 64'd1);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    @(negedge clk_i);
    chk("coll_bvalid", 64'(b_valid_o), 64'd1);
    if (b_valid_o) exp_wr++;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      if (r_valid_o) begin d = r_data_o; seen = 1; exp_rd++; end
      else @(negedge clk_i);
    end
    chk("coll_seen", 64'(seen), 64'd1);
    chk("coll_old_data", 64'(d), 64'd1);
    do_read(32'h8000_000C, d, rs);
    chk("coll_new_data", 64'(d), 64'd2);
    @(negedge clk_i);
    chk("pre_rst_rd_count", 64'(rd_count_o), 64'(exp_rd));
    chk("pre_rst_wr_count", 64'(wr_count_o), 64'(exp_wr));

    // Reset with three reads in flight.
    r_ready_i = 1'b0;
    @(posedge clk_i); #1;
    ar_valid_i = 1'b1; ar_addr_i = 32'h8000_0000;
    repeat (3) begin
      @(posedge clk_i); #1;
      ar_addr_i = ar_addr_i + 32'd4;
    end
    ar_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_ar_ready", 64'(ar_ready_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("midrst_valids", 64'({r_valid_o, b_valid_o}), 64'd0);
    chk("midrst_rdata_resp", 64'({r_data_o, r_resp_o, b_resp_o}), 64'd0);
    chk("midrst_counts", {rd_count_o, wr_count_o}, 64'd0);
    exp_rd = 0; exp_wr = 0;
    r_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rel_ar_ready", 64'(ar_ready_o), 64'd1);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (r_valid_o) seen++;
      @(negedge clk_i);
    end
    chk("rel_no_r_beats", 64'(seen), 64'd0);
    do_read(32'h8000_0004, d, rs);
    chk("rel_mem_kept", 64'(d), 64'hAA22_CC44);
    @(negedge clk_i);
    chk("rel_rd_count", 64'(rd_count_o), 64'(exp_rd));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
